// File: rtl/ff_edge_counter_if.sv
// Snapshot request/acknowledge channel for ff_edge_counter.
// A master raises snap_req_in and holds it until snap_ack_out is seen.
// The slave returns a captured count on snap_out, which is stable while the ack is high.
interface ff_edge_counter_if #(
    parameter int CNT_W = 8
);
    logic             snap_req_in;
    logic [CNT_W-1:0] snap_out;
    logic             snap_ack_out;

    // The requester drives req and observes the returned data and ack.
    modport master (
        output snap_req_in,
        input  snap_out,
        input  snap_ack_out
    );

    // The counter observes req and returns the data and ack.
    modport slave (
        input  snap_req_in,
        output snap_out,
        output snap_ack_out
    );
endinterface

// File: rtl/ff_edge_counter.sv
// ff_edge_counter: counts qualified transitions of an upstream flop's q_out bit.
//  - Edge detection runs on a two-register sample chain (q_s/q_d).
//  - The detected edge is registered once more before it is counted, so a q_in change
//    at edge N shows up on count_out and edge_out at edge N+2.
//  - The counter either saturates (SATURATE=1) or wraps (SATURATE=0). A sticky ovf flag
//    records an increment attempted at the maximum count.
//  - Snapshots of the count are returned over a 4-phase req/ack handshake, carried by
//    ff_edge_counter_if.
// Optional feature: define EDGE_SYNC_EN to add a 2-flop input synchronizer ahead of q_s.
//  - Input latency becomes N+4.
//  - S_INIT is stretched to 3 cycles so that the synchronizer is full before the first
//    edge comparison.
module ff_edge_counter #(
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             q_in,
    input  logic [1:0]       mode_in,
    input  logic             clear_in,
    input  logic [CNT_W-1:0] thresh_in,
    output logic [CNT_W-1:0] count_out,
    output logic             edge_out,
    output logic             hit_out,
    output logic             ovf_out,
    ff_edge_counter_if.slave snap
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef EDGE_SYNC_EN
    localparam logic [1:0] INIT_LAST = 2'd2;
`else
    localparam logic [1:0] INIT_LAST = 2'd0;
`endif

    // Mode encodings
    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    state_t           state_q, state_d;
    logic [1:0]       init_cnt_q, init_cnt_d;
    logic             q_s_q, q_s_d;
    logic             q_d_q, q_d_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             edge_q, edge_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic             ack_q, ack_d;

    logic             q_src;
    logic             qual;
    logic [CNT_W-1:0] count_inc;

`ifdef EDGE_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchronizer for an asynchronous q_in
    always_ff @(posedge clk) begin
        if (reset_in) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= q_in;
            sync2_q <= sync1_q;
        end
    end

    assign q_src = sync2_q;
`else
    assign q_src = q_in;
`endif

    assign count_inc = count_q + 1'b1;

    // Qualify the registered edge against the mode sampled in the counting cycle
    always_comb begin
        qual = 1'b0;
        case (mode_in)
            MODE_RISE: qual = rise_q;
            MODE_FALL: qual = fall_q;
            MODE_BOTH: qual = rise_q | fall_q;
            default:   qual = 1'b0;
        endcase
    end

    // Next-state logic: FSM, sample chain, counter, flags and snapshot handshake
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        q_s_d      = q_src;
        q_d_d      = q_s_q;
        rise_d     = q_s_q & ~q_d_q;
        fall_d     = ~q_s_q & q_d_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        edge_d     = 1'b0;
        hit_d      = 1'b0;
        snap_d     = snap_q;
        ack_d      = ack_q;

        case (state_q)
            S_INIT: begin
                // Both sample regs take the current level, so the level present at
                // reset release never looks like a transition.
                q_s_d  = q_src;
                q_d_d  = q_src;
                rise_d = 1'b0;
                fall_d = 1'b0;
                if (init_cnt_q == INIT_LAST) begin
                    init_cnt_d = 2'd0;
                    state_d    = S_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 2'd1;
                end
            end

            S_RUN: begin
                if (clear_in) begin
                    // A clear beats an edge that is counted in the same cycle.
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (qual) begin
                    if (count_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                        if (SATURATE) begin
                            state_d = S_FULL;
                        end else begin
                            count_d = '0;
                            edge_d  = 1'b1;
                            hit_d   = (thresh_in == '0);
                        end
                    end else begin
                        count_d = count_inc;
                        edge_d  = 1'b1;
                        hit_d   = (count_inc == thresh_in);
                        if (SATURATE && (count_inc == CNT_MAX)) begin
                            state_d = S_FULL;
                        end
                    end
                end
            end

            S_FULL: begin
                // The count is pinned at the maximum. Further edges only record overflow.
                if (clear_in) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end else if (qual) begin
                    ovf_d = 1'b1;
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase

        // The snapshot takes the count of this cycle, before any increment lands.
        if (snap.snap_req_in && !ack_q) begin
            snap_d = count_q;
            ack_d  = 1'b1;
        end else if (!snap.snap_req_in && ack_q) begin
            ack_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q    <= S_INIT;
            init_cnt_q <= 2'd0;
            q_s_q      <= 1'b0;
            q_d_q      <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            edge_q     <= 1'b0;
            hit_q      <= 1'b0;
            snap_q     <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            q_s_q      <= q_s_d;
            q_d_q      <= q_d_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            edge_q     <= edge_d;
            hit_q      <= hit_d;
            snap_q     <= snap_d;
            ack_q      <= ack_d;
        end
    end

    assign count_out         = count_q;
    assign edge_out          = edge_q;
    assign hit_out           = hit_q;
    assign ovf_out           = ovf_q;
    assign snap.snap_out     = snap_q;
    assign snap.snap_ack_out = ack_q;

endmodule

// File: tb/tb_ff_edge_counter.sv
// Bench for ff_edge_counter.
// Three instances share one stimulus stream:
//  - 8-bit saturating
//  - 4-bit saturating
//  - 4-bit wrapping
// A reference model keeps the sampled q_in history and applies the counting rules
// directly. It pushes expected edge events and snapshot values into queues. A negedge
// monitor pops those entries when the DUT pulses edge_out or raises snap_ack_out.
module tb_ff_edge_counter;

    localparam int NI = 3;
`ifdef EDGE_SYNC_EN
    localparam int LAT      = 4;
    localparam int INIT_CYC = 3;
`else
    localparam int LAT      = 2;
    localparam int INIT_CYC = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, q, clr, req;
    logic [1:0] mode;
    logic [7:0] thr;

    always #5 clk = ~clk;

    ff_edge_counter_if #(.CNT_W(8)) sif0 ();
    ff_edge_counter_if #(.CNT_W(4)) sif1 ();
    ff_edge_counter_if #(.CNT_W(4)) sif2 ();

    assign sif0.snap_req_in = req;
    assign sif1.snap_req_in = req;
    assign sif2.snap_req_in = req;

    logic [7:0]    c0;
    logic [3:0]    c1, c2;
    logic [NI-1:0] eo, ho, oo;

    ff_edge_counter #(.CNT_W(8), .SATURATE(1'b1)) dut0 (
        .clk(clk), .reset_in(rst), .q_in(q), .mode_in(mode), .clear_in(clr),
        .thresh_in(thr), .count_out(c0), .edge_out(eo[0]), .hit_out(ho[0]),
        .ovf_out(oo[0]), .snap(sif0.slave));

    ff_edge_counter #(.CNT_W(4), .SATURATE(1'b1)) dut1 (
        .clk(clk), .reset_in(rst), .q_in(q), .mode_in(mode), .clear_in(clr),
        .thresh_in(thr[3:0]), .count_out(c1), .edge_out(eo[1]), .hit_out(ho[1]),
        .ovf_out(oo[1]), .snap(sif1.slave));

    ff_edge_counter #(.CNT_W(4), .SATURATE(1'b0)) dut2 (
        .clk(clk), .reset_in(rst), .q_in(q), .mode_in(mode), .clear_in(clr),
        .thresh_in(thr[3:0]), .count_out(c2), .edge_out(eo[2]), .hit_out(ho[2]),
        .ovf_out(oo[2]), .snap(sif2.slave));

    logic [7:0] cnt_a[NI];
    logic [7:0] snp_a[NI];
    logic       ack_a[NI];

    assign cnt_a[0] = c0;
    assign cnt_a[1] = {4'b0, c1};
    assign cnt_a[2] = {4'b0, c2};
    assign snp_a[0] = sif0.snap_out;
    assign snp_a[1] = {4'b0, sif1.snap_out};
    assign snp_a[2] = {4'b0, sif2.snap_out};
    assign ack_a[0] = sif0.snap_ack_out;
    assign ack_a[1] = sif1.snap_ack_out;
    assign ack_a[2] = sif2.snap_ack_out;

    typedef struct {
        int cnt;
        bit hit;
        bit ovf;
    } ev_t;

    // Reference model state
    int  mmax[NI] = '{255, 15, 15};
    bit  msat[NI] = '{1'b1, 1'b1, 1'b0};
    int  mcnt[NI];
    bit  movf[NI];
    bit  mack[NI];
    int  minit[NI];
    bit  mfill[NI];
    bit  hist[NI][0:5];
    ev_t evq[NI][$];
    int  snapq[NI][$];

    int  ncmp = 0;
    int  nerr = 0;
    bit  chk_en = 1'b0;
    bit  prev_ack[NI];

    task automatic chk(input string nm, input int i, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            if (nerr <= 40)
                $display("FAIL %s inst%0d @%0t: got %0d, expected %0d", nm, i, $time, act, exp);
        end
    endtask

    // One clock edge of the reference model, using the inputs the DUT samples at that edge.
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                mcnt[i]  = 0;
                movf[i]  = 1'b0;
                mack[i]  = 1'b0;
                minit[i] = INIT_CYC;
                mfill[i] = 1'b1;
                snapq[i].delete();
                evq[i].delete();
            end else begin
                bit r, f, qual;
                ev_t ev;

                if (req && !mack[i]) begin
                    snapq[i].push_back(mcnt[i]);
                    mack[i] = 1'b1;
                end else if (!req && mack[i]) begin
                    mack[i] = 1'b0;
                end

                if (minit[i] > 0) begin
                    if (mfill[i]) begin
                        for (int j = 0; j <= LAT; j++) hist[i][j] = q;
                        mfill[i] = 1'b0;
                    end else begin
                        for (int j = LAT; j > 0; j--) hist[i][j] = hist[i][j-1];
                        hist[i][0] = q;
                    end
                    minit[i]--;
                end else begin
                    r    = hist[i][LAT-1] & ~hist[i][LAT];
                    f    = ~hist[i][LAT-1] & hist[i][LAT];
                    qual = (mode == 2'd0 && r) || (mode == 2'd1 && f) || (mode == 2'd2 && (r || f));
                    if (clr) begin
                        mcnt[i] = 0;
                        movf[i] = 1'b0;
                    end else if (qual) begin
                        if (mcnt[i] == mmax[i]) begin
                            movf[i] = 1'b1;
                            if (!msat[i]) begin
                                mcnt[i] = 0;
                                ev.cnt = 0;
                                ev.hit = ((int'(thr) & mmax[i]) == 0);
                                ev.ovf = 1'b1;
                                evq[i].push_back(ev);
                            end
                        end else begin
                            mcnt[i] = mcnt[i] + 1;
                            ev.cnt = mcnt[i];
                            ev.hit = ((int'(thr) & mmax[i]) == mcnt[i]);
                            ev.ovf = movf[i];
                            evq[i].push_back(ev);
                        end
                    end
                    for (int j = LAT; j > 0; j--) hist[i][j] = hist[i][j-1];
                    hist[i][0] = q;
                end
            end
        end
    endtask

    // Monitor: runs on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                if (eo[i]) begin
                    if (evq[i].size() == 0) begin
                        chk("edge_spurious", i, 1, 0);
                    end else begin
                        ev_t e;
                        e = evq[i].pop_front();
                        chk("edge_count", i, int'(cnt_a[i]), e.cnt);
                        chk("edge_hit", i, int'(ho[i]), int'(e.hit));
                        chk("edge_ovf", i, int'(oo[i]), int'(e.ovf));
                    end
                end else begin
                    chk("hit_without_edge", i, int'(ho[i]), 0);
                end
                chk("edge_missing", i, evq[i].size(), 0);
                evq[i].delete();
                chk("count", i, int'(cnt_a[i]), mcnt[i]);
                chk("ovf", i, int'(oo[i]), int'(movf[i]));
                chk("ack", i, int'(ack_a[i]), int'(mack[i]));
                if (ack_a[i] && !prev_ack[i]) begin
                    if (snapq[i].size() == 0) chk("snap_spurious", i, 1, 0);
                    else chk("snap_value", i, int'(snp_a[i]), snapq[i].pop_front());
                end
                prev_ack[i] = ack_a[i];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) begin
            q = 1'b1;
            repeat (hi) tick();
            q = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int guard;

        rst  = 1'b1;
        q    = 1'b1;
        clr  = 1'b0;
        req  = 1'b0;
        mode = 2'd0;
        thr  = 8'd0;
        for (int i = 0; i < NI; i++) prev_ack[i] = 1'b0;

        // Reset with q high; the initial level must not count.
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        q = 1'b0;
        repeat (4) tick();

        // Rising edges only
        pulses(5, 2, 2);
        repeat (3) tick();

        // Both edges, then counting disabled
        do_clear();
        mode = 2'd2;
        for (int k = 0; k < 4; k++) begin
            q = ~q;
            repeat (3) tick();
        end
        mode = 2'd3;
        for (int k = 0; k < 4; k++) begin
            q = ~q;
            repeat (3) tick();
        end

        // Falling edges only
        mode = 2'd1;
        pulses(3, 2, 2);

        // 17 rises: saturate / wrap on the 4-bit instances
        mode = 2'd0;
        q    = 1'b0;
        repeat (3) tick();
        do_clear();
        pulses(17, 1, 1);
        repeat (3) tick();
        do_clear();
        repeat (2) tick();

        // Threshold hit, then a clear in the same cycle as a counted rise
        thr = 8'd3;
        pulses(3, 2, 2);
        repeat (2) tick();
        q = 1'b1;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        q   = 1'b0;
        repeat (3) tick();

        // Snapshot in the same cycle as a counted edge, then reset during ack
        do_clear();
        thr = 8'd0;
        pulses(7, 2, 2);
        q = 1'b1;
        tick();
        tick();
        req = 1'b1;
        tick();
        tick();
        req = 1'b0;
        repeat (3) tick();
        req   = 1'b1;
        guard = 0;
        while (!sif0.snap_ack_out && guard < 20) begin
            tick();
            guard++;
        end
        chk("ack_timeout", 0, guard < 20 ? 1 : 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 1'b0;
        q   = 1'b0;
        repeat (4) tick();

        // Random traffic, with occasional clears, mode and threshold changes and resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) q = ~q;
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            clr = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) thr = 8'($urandom_range(0, 20));
            if (!req && !sif0.snap_ack_out && $urandom_range(0, 5) == 0) req = 1'b1;
            else if (req && sif0.snap_ack_out && $urandom_range(0, 1) == 0) req = 1'b0;
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        clr = 1'b0;
        repeat (4) tick();

        // Long run with no clears, to push the 8-bit instance into saturation
        do_clear();
        mode = 2'd2;
        for (int c = 0; c < 1200; c++) begin
            if ($urandom_range(0, 1) == 0) q = ~q;
            if (!req && !sif0.snap_ack_out && $urandom_range(0, 7) == 0) req = 1'b1;
            else if (req && sif0.snap_ack_out) req = 1'b0;
            tick();
        end
        req = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < NI; i++) begin
            chk("final_evq_empty", i, evq[i].size(), 0);
            chk("final_snapq_empty", i, snapq[i].size(), 0);
        end
        chk("sat8_reached", 0, int'(c0), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
